// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port data memory between the core datapath (port C)
//   and an external host/debug port (port H). At most one access is granted
//   per cycle. The core has fixed priority, but a host request that has been
//   denied HOST_MAX_WAIT consecutive cycles is granted on the next cycle.
//
// Ports
//   clk, nReset                     clock (rising edge), async active-low reset
//   CoreReq/WE/Addr/WData  (in)     core request bundle
//   CoreGnt, CoreStall     (out)    core grant; stall = CoreReq & ~CoreGnt
//   CoreRData, CoreRValid  (out)    registered read data and 1-cycle valid
//   HostReq/WE/Addr/WData  (in)     host request bundle
//   HostGnt                (out)    host grant
//   HostRData, HostRValid  (out)    registered read data and 1-cycle valid
//   MemWE, MemAddr, MemWData (out)  memory write enable, address, write data
//   MemRData               (in)     combinational memory read data
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned HOST_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic                  CoreReq,
  input  logic                  CoreWE,
  input  logic [ADDR_WIDTH-1:0] CoreAddr,
  input  logic [DATA_WIDTH-1:0] CoreWData,
  output logic                  CoreGnt,
  output logic                  CoreStall,
  output logic [DATA_WIDTH-1:0] CoreRData,
  output logic                  CoreRValid,
  input  logic                  HostReq,
  input  logic                  HostWE,
  input  logic [ADDR_WIDTH-1:0] HostAddr,
  input  logic [DATA_WIDTH-1:0] HostWData,
  output logic                  HostGnt,
  output logic [DATA_WIDTH-1:0] HostRData,
  output logic                  HostRValid,
  output logic                  MemWE,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic [DATA_WIDTH-1:0] MemRData
);

  localparam int unsigned CW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(HOST_MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(HOST_MAX_WAIT - 1);

  typedef enum logic {
    CORE_PRI   = 1'b0,
    HOST_FORCE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  core_gnt, host_gnt;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic                  core_rvalid_q, core_rvalid_d;
  logic                  host_rvalid_q, host_rvalid_d;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= CORE_PRI;
      wait_cnt_q    <= '0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      core_rdata_q  <= core_rdata_d;
      host_rdata_q  <= host_rdata_d;
      core_rvalid_q <= core_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  // Grant selection, starvation counter and state transitions.
  always_comb begin
    core_gnt   = 1'b0;
    host_gnt   = 1'b0;
    state_d    = state_q;
    wait_cnt_d = '0;

    // Grants are suppressed while reset is held so nothing reaches memory.
    if (nReset) begin
      case (state_q)
        CORE_PRI: begin
          core_gnt = CoreReq;
          host_gnt = HostReq & ~CoreReq;
        end
        HOST_FORCE: begin
          host_gnt = HostReq;
          core_gnt = CoreReq & ~HostReq;
        end
        default: begin
          core_gnt = 1'b0;
          host_gnt = 1'b0;
        end
      endcase
    end

    // Counts consecutive denied host cycles; any host grant or idle host clears it.
    if (HostReq && !host_gnt) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end

    case (state_q)
      CORE_PRI: begin
        if (HostReq && !host_gnt && (wait_cnt_q == WAIT_LAST)) begin
          state_d = HOST_FORCE;
        end
      end
      HOST_FORCE: begin
        // The forced slot is consumed by any grant, even one that goes to
        // the core because the host dropped its request.
        if (core_gnt || host_gnt) begin
          state_d    = CORE_PRI;
          wait_cnt_d = '0;
        end
      end
      default: state_d = CORE_PRI;
    endcase
  end

  // Read-return registers: capture memory data for the port that won a read.
  always_comb begin
    core_rdata_d  = core_rdata_q;
    host_rdata_d  = host_rdata_q;
    core_rvalid_d = core_gnt & ~CoreWE;
    host_rvalid_d = host_gnt & ~HostWE;
    if (core_rvalid_d) core_rdata_d = MemRData;
    if (host_rvalid_d) host_rdata_d = MemRData;
  end

  // Memory port mux; idle cycles present zeros.
  always_comb begin
    MemWE    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    if (core_gnt) begin
      MemWE    = CoreWE;
      MemAddr  = CoreAddr;
      MemWData = CoreWData;
    end else if (host_gnt) begin
      MemWE    = HostWE;
      MemAddr  = HostAddr;
      MemWData = HostWData;
    end
  end

  assign CoreGnt    = core_gnt;
  assign HostGnt    = host_gnt;
  assign CoreStall  = CoreReq & ~core_gnt;
  assign CoreRData  = core_rdata_q;
  assign CoreRValid = core_rvalid_q;
  assign HostRData  = host_rdata_q;
  assign HostRValid = host_rvalid_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int HMW = 4;

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic          CoreReq = 1'b0, CoreWE = 1'b0;
  logic [AW-1:0] CoreAddr = '0;
  logic [DW-1:0] CoreWData = '0;
  logic          CoreGnt, CoreStall, CoreRValid;
  logic [DW-1:0] CoreRData;
  logic          HostReq = 1'b0, HostWE = 1'b0;
  logic [AW-1:0] HostAddr = '0;
  logic [DW-1:0] HostWData = '0;
  logic          HostGnt, HostRValid;
  logic [DW-1:0] HostRData;
  logic          MemWE;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData;

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOST_MAX_WAIT(HMW)) dut (
    .clk(clk), .nReset(nReset),
    .CoreReq(CoreReq), .CoreWE(CoreWE), .CoreAddr(CoreAddr), .CoreWData(CoreWData),
    .CoreGnt(CoreGnt), .CoreStall(CoreStall), .CoreRData(CoreRData), .CoreRValid(CoreRValid),
    .HostReq(HostReq), .HostWE(HostWE), .HostAddr(HostAddr), .HostWData(HostWData),
    .HostGnt(HostGnt), .HostRData(HostRData), .HostRValid(HostRValid),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
  );

  always #5 clk = ~clk;

  // Data memory attached to the arbiter.
  logic [DW-1:0] env_mem [64];
  assign MemRData = env_mem[MemAddr];
  always @(posedge clk) if (MemWE) env_mem[MemAddr] <= MemWData;

  // Reference model: expected memory image, read-return registers, and the
  // host fairness rule (run of denied host cycles, pending forced slot).
  logic [DW-1:0] m_mem [64];
  bit            m_force;
  int            m_run;
  logic [DW-1:0] m_crd, m_hrd;
  bit            m_crv, m_hrv;

  int n_chk = 0;
  int n_fail = 0;

  // Last observed values, for directed pattern checks.
  logic          last_cg, last_hg, last_stall, last_mwe, last_crv, last_hrv;
  logic [DW-1:0] last_crd, last_hrd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_force = 0; m_run = 0;
    m_crd = '0; m_hrd = '0; m_crv = 0; m_hrv = 0;
  endtask

  // One clock cycle: drive requests, check at the falling edge, then advance the model.
  task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    bit            e_cg, e_hg, fwas;
    logic          e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    CoreReq = cr; CoreWE = cw; CoreAddr = ca; CoreWData = cd;
    HostReq = hr; HostWE = hw; HostAddr = ha; HostWData = hd;
    @(negedge clk);
    if (!nReset)      begin e_cg = 0;  e_hg = 0; end
    else if (m_force) begin e_hg = hr; e_cg = cr && !hr; end
    else              begin e_cg = cr; e_hg = hr && !cr; end
    e_we = 0; e_a = '0; e_d = '0;
    if (e_cg)      begin e_we = cw; e_a = ca; e_d = cd; end
    else if (e_hg) begin e_we = hw; e_a = ha; e_d = hd; end
    check("CoreGnt", CoreGnt, e_cg);
    check("HostGnt", HostGnt, e_hg);
    check("CoreStall", CoreStall, cr && !e_cg);
    check("MemWE", MemWE, e_we);
    check("MemAddr", MemAddr, e_a);
    check("MemWData", MemWData, e_d);
    check("CoreRValid", CoreRValid, m_crv);
    check("CoreRData", CoreRData, m_crd);
    check("HostRValid", HostRValid, m_hrv);
    check("HostRData", HostRData, m_hrd);
    last_cg = CoreGnt; last_hg = HostGnt; last_stall = CoreStall; last_mwe = MemWE;
    last_crv = CoreRValid; last_crd = CoreRData; last_hrv = HostRValid; last_hrd = HostRData;
    @(posedge clk);
    if (nReset) begin
      m_crv = 0; m_hrv = 0;
      if (e_cg) begin
        if (cw) m_mem[ca] = cd; else begin m_crd = m_mem[ca]; m_crv = 1; end
      end
      if (e_hg) begin
        if (hw) m_mem[ha] = hd; else begin m_hrd = m_mem[ha]; m_hrv = 1; end
      end
      fwas = m_force;
      if (fwas && (e_cg || e_hg)) begin
        m_force = 0; m_run = 0;
      end else if (hr && !e_hg) begin
        m_run++;
        if (m_run >= HMW) m_force = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [9:0] cpat, hpat;
    logic [4:0] fpat;
    bit         any_crv;
    bit         c_pend, h_pend;
    logic       c_we, h_we;
    logic [AW-1:0] c_a, h_a;
    logic [DW-1:0] c_d, h_d;

    m_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    @(posedge clk); #1;

    // Reset held with both ports requesting.
    step(1, 1, 6'd1, 8'h11, 1, 1, 6'd2, 8'h22);
    check("rst_cg", last_cg, 1'b0);
    check("rst_hg", last_hg, 1'b0);
    check("rst_stall", last_stall, 1'b1);
    check("rst_mwe", last_mwe, 1'b0);
    check("rst_crd", last_crd, 8'h00);
    nReset = 1'b1;
    step(1, 1, 6'd0, 8'h00, 1, 1, 6'd2, 8'h22);
    check("rel_cg", last_cg, 1'b1);

    // Preload the whole memory through the host port.
    for (int i = 0; i < 64; i++) step(0, 0, '0, '0, 1, 1, AW'(i), DW'($urandom));

    // Core only: write then read address 5.
    step(1, 1, 6'd5, 8'hA5, 0, 0, '0, '0);
    check("core_wr_gnt", last_cg, 1'b1);
    check("core_wr_we", last_mwe, 1'b1);
    step(1, 0, 6'd5, 8'h00, 0, 0, '0, '0);
    check("core_rd_gnt", last_cg, 1'b1);
    check("core_rd_we", last_mwe, 1'b0);
    idle();
    check("core_rvalid", last_crv, 1'b1);
    check("core_rdata", last_crd, 8'hA5);

    // Host only: write then read address 63.
    step(0, 0, '0, '0, 1, 1, 6'd63, 8'h3C);
    check("host_wr_gnt", last_hg, 1'b1);
    any_crv = last_crv;
    step(0, 0, '0, '0, 1, 0, 6'd63, 8'h00);
    check("host_rd_gnt", last_hg, 1'b1);
    any_crv |= last_crv;
    idle();
    any_crv |= last_crv;
    check("host_rvalid", last_hrv, 1'b1);
    check("host_rdata", last_hrd, 8'h3C);
    check("host_no_crv", any_crv, 1'b0);

    // Continuous contention.
    cpat = '0; hpat = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, AW'(i % 8), '0, 1, 0, 6'd40, '0);
      cpat[i] = last_cg; hpat[i] = last_hg;
      if (i == 4) check("contend_stall4", last_stall, 1'b1);
    end
    check("contend_core", cpat, 10'b0111101111);
    check("contend_host", hpat, 10'b1000010000);

    // Forced slot left unused by the host.
    for (int i = 0; i < 4; i++) step(1, 0, 6'd3, '0, 1, 0, 6'd7, '0);
    step(1, 0, 6'd3, '0, 0, 0, '0, '0);
    check("force_unused_cg", last_cg, 1'b1);
    fpat = '0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 6'd4, '0, 1, 0, 6'd8, '0);
      fpat[i] = last_hg;
    end
    check("force_rewait", fpat, 5'b10000);
    idle();

    // Reset asserted during a granted core read.
    CoreReq = 1; CoreWE = 0; CoreAddr = 6'd10; CoreWData = '0;
    HostReq = 0; HostWE = 0; HostAddr = '0; HostWData = '0;
    @(negedge clk);
    check("midrd_gnt", CoreGnt, 1'b1);
    #2 nReset = 1'b0;
    m_reset();
    @(posedge clk); #1;
    step(1, 0, 6'd10, '0, 0, 0, '0, '0);
    step(1, 0, 6'd10, '0, 0, 0, '0, '0);
    check("midrd_rst_stall", last_stall, 1'b1);
    nReset = 1'b1;
    step(1, 0, 6'd10, '0, 0, 0, '0, '0);
    check("midrd_no_rvalid", last_crv, 1'b0);
    check("midrd_rdata", last_crd, 8'h00);
    idle();

    // Randomized traffic; each port holds its request until granted.
    c_pend = 0; h_pend = 0;
    c_we = 0; h_we = 0; c_a = '0; h_a = '0; c_d = '0; h_d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1; c_we = 1'($urandom); c_a = AW'($urandom_range(0, 7)); c_d = DW'($urandom);
      end
      if (!h_pend && $urandom_range(0, 2) != 0) begin
        h_pend = 1; h_we = 1'($urandom); h_a = AW'($urandom_range(0, 7)); h_d = DW'($urandom);
      end
      step(c_pend, c_we, c_a, c_d, h_pend, h_we, h_a, h_d);
      if (last_cg) c_pend = 0;
      if (last_hg) h_pend = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Single-port data memory arbiter sharing the 8-bit core's data memory between the core datapath (port C) and an external host/debug port (port H). It grants at most one access per cycle and drives the memory's write-enable, address and write data. It registers read data back to the winning requester and produces a stall for the core's program counter. Priority is fixed to the core, with a starvation bound that guarantees the host a slot.

## Interface
- ADDR_WIDTH, 6, data memory address width (64 locations)
- DATA_WIDTH, 8, data word width (accumulator width)
- HOST_MAX_WAIT, 4, max consecutive denied host-request cycles before a forced host grant; legal range ≥1
- clk  in  1  system clock, rising edge
- nReset  in  1  asynchronous, active-low reset
- CoreReq  in  1  core access request
- CoreWE  in  1  1 = write, 0 = read
- CoreAddr  in  ADDR_WIDTH  core address
- CoreWData  in  DATA_WIDTH  core write data (accumulator value)
- CoreGnt  out  1  core granted this cycle
- CoreStall  out  1  CoreReq & ~CoreGnt; holds the PC
- CoreRData  out  DATA_WIDTH  registered read data for the core
- CoreRValid  out  1  one-cycle pulse; CoreRData is valid
- HostReq, HostWE, HostAddr, HostWData  in  1/1/ADDR_WIDTH/DATA_WIDTH  host request bundle, same meaning as the core bundle
- HostGnt, HostRData, HostRValid  out  1/DATA_WIDTH/1  host grant, read data, read valid
- MemWE  out  1  memory write enable
- MemAddr  out  ADDR_WIDTH  memory address
- MemWData  out  DATA_WIDTH  memory write data
- MemRData  in  DATA_WIDTH  memory combinational read data

## Operation
- Requesters hold Req/WE/Addr/WData stable until the cycle in which Gnt=1. A requester drops Req, or presents its next access, in the cycle after the grant.
- FSM states:
  - CORE_PRI (reset state): core wins whenever CoreReq=1; host wins only when CoreReq=0.
  - HOST_FORCE: host wins whenever HostReq=1; core wins if HostReq=0.
- WaitCnt, width clog2(HOST_MAX_WAIT+1):
  - Increments on each cycle with HostReq & ~HostGnt.
  - Clears on a host grant, or when HostReq=0.
  - Saturates at HOST_MAX_WAIT.
- Transitions:
  - CORE_PRI→HOST_FORCE when the host is denied and WaitCnt is HOST_MAX_WAIT-1 in that cycle.
  - HOST_FORCE→CORE_PRI after any grant, whether to the host or to the core because HostReq dropped. WaitCnt clears on this transition.
- Grants are combinational from the requests and the registered state. CoreGnt and HostGnt are never both 1.
- Memory outputs are muxed from the granted port:
  - MemWE = granted WE.
  - With no grant, MemWE=0 and MemAddr/MemWData = 0.
- Write: the memory captures data at the rising edge that ends the grant cycle.
- Read:
  - At the edge ending a granted read, MemRData is registered into the winner's RData, and that port's RValid=1 for exactly the next cycle.
  - RData holds its value until that port's next read.
  - A granted write produces no RValid.
- Reset:
  - All registers clear asynchronously: state=CORE_PRI, WaitCnt=0, CoreRData=HostRData=0, CoreRValid=HostRValid=0.
  - While nReset=0, CoreGnt, HostGnt and MemWE are forced to 0, so CoreStall = CoreReq.
  - A read granted in the cycle during which reset asserts produces no RValid after release.

## Timing
- Grant latency: 0 cycles for an uncontended request.
- Read data latency: 1 cycle after the grant.
- Write commits at the end of the grant cycle.
- Worst-case host wait is HOST_MAX_WAIT denied cycles; the host is granted in cycle HOST_MAX_WAIT+1 of a continuous request.
- Worst-case core stall is 1 cycle per forced host slot.
- Back-to-back accesses from one port: a grant every cycle. RValid pulses line up one cycle behind each read grant.
- Read-after-write to the same address on consecutive grants returns the new data.

## Test plan
- Reset: assert nReset=0 with both Req=1 → both Gnt=0, MemWE=0, RValid=0, RData=0, CoreStall=1; release → core granted in the first cycle.
- Core only: write 0xA5 to address 5, then read address 5 → CoreGnt in both cycles, MemWE=1 only in the first, CoreRValid=1 with CoreRData=0xA5 in the third cycle.
- Host only, CoreReq=0: host write 0x3C to address 63, then read → HostGnt each cycle, HostRData=0x3C one cycle later, CoreRValid never asserts.
- Contention, HOST_MAX_WAIT=4, both requesting continuously → CoreGnt in cycles 0-3, HostGnt and CoreStall=1 in cycle 4, CoreGnt in cycles 5-8, HostGnt in cycle 9.
- Forced slot unused: reach HOST_FORCE, then drop HostReq → CoreGnt in that cycle, state returns to CORE_PRI, and a new host request waits the full 4 cycles again.
- Reset mid-read: core read grant to address 10, assert nReset low before the next edge for 2 cycles → no CoreRValid after release, CoreRData=0.
